// File: rtl/shift_register_loader_if.sv
// shift_register_loader_if: operand/result bus between the loader and its driver.
// Carries misr only when SHIFT_REGISTER_LOADER_MISR_EN is defined.
interface shift_register_loader_if #(
    parameter int NUM_SRC   = 20,
    parameter int SRC_WIDTH = 20,
    parameter int DST_WIDTH = 26
`ifdef SHIFT_REGISTER_LOADER_MISR_EN
    , parameter int MISR_WIDTH = 32
`endif
);
    logic                           clear;
    logic                           shift_en;
    logic [NUM_SRC-1:0]             src_;
    logic [NUM_SRC*SRC_WIDTH-1:0]   src;
    logic                           src_valid;
    logic [DST_WIDTH-1:0]           dst_in;
    logic [DST_WIDTH-1:0]           dst_out;
    logic                           dst_valid;
`ifdef SHIFT_REGISTER_LOADER_MISR_EN
    logic [MISR_WIDTH-1:0]          misr;
`endif
    modport master (
        output clear, shift_en, src_, dst_in,
        input  src, src_valid, dst_out, dst_valid
`ifdef SHIFT_REGISTER_LOADER_MISR_EN
        , input misr
`endif
    );
    modport slave (
        input  clear, shift_en, src_, dst_in,
        output src, src_valid, dst_out, dst_valid
`ifdef SHIFT_REGISTER_LOADER_MISR_EN
        , output misr
`endif
    );
endinterface

// File: rtl/shift_register_loader.sv
// shift_register_loader: serial operand loader with fill tracking and registered result capture.
// Optional result signature register enabled by SHIFT_REGISTER_LOADER_MISR_EN.
module shift_register_loader #(
    parameter int NUM_SRC   = 20,
    parameter int SRC_WIDTH = 20,
    parameter int DST_WIDTH = 26
`ifdef SHIFT_REGISTER_LOADER_MISR_EN
    , parameter int MISR_WIDTH = 32
`endif
) (
    input logic clk,
    input logic rst,
    shift_register_loader_if.slave bus
);
    localparam int cnt_w = $clog2(SRC_WIDTH + 1);
    logic [NUM_SRC*SRC_WIDTH-1:0] ops;
    logic [NUM_SRC*SRC_WIDTH-1:0] ops_nxt;
    logic [cnt_w-1:0]             cnt;
    logic                         vld;
    logic [DST_WIDTH-1:0]         dst_q;
    logic                         dv;
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
        assign ops_nxt[i*SRC_WIDTH +: SRC_WIDTH] = {ops[i*SRC_WIDTH +: SRC_WIDTH-1], bus.src_[i]};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops   <= '0;
            cnt   <= '0;
            vld   <= 1'b0;
            dst_q <= '0;
            dv    <= 1'b0;
        end else if (bus.clear) begin
            ops   <= '0;
            cnt   <= '0;
            vld   <= 1'b0;
            dst_q <= '0;
            dv    <= 1'b0;
        end else begin
            dst_q <= bus.dst_in;
            dv    <= vld;
            if (bus.shift_en) begin
                ops <= ops_nxt;
                cnt <= (cnt == cnt_w'(SRC_WIDTH)) ? cnt : cnt + 1'b1;
                // valid stays set once reached: the window keeps sliding
                vld <= vld | (cnt >= cnt_w'(SRC_WIDTH - 1));
            end
        end
    end
    assign bus.src       = ops;
    assign bus.src_valid = vld;
    assign bus.dst_out   = dst_q;
    assign bus.dst_valid = dv;
`ifdef SHIFT_REGISTER_LOADER_MISR_EN
    localparam logic [MISR_WIDTH-1:0] poly = MISR_WIDTH'(32'h00400007);
    logic [MISR_WIDTH-1:0] sig;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sig <= '0;
        else if (bus.clear)
            sig <= '0;
        else if (vld)
            sig <= {sig[MISR_WIDTH-2:0], 1'b0} ^ (sig[MISR_WIDTH-1] ? poly : '0) ^ MISR_WIDTH'(bus.dst_in);
    end
    assign bus.misr = sig;
`endif
endmodule

// File: tb/tb_shift_register_loader.sv
// tb_shift_register_loader: randomized scoreboard bench; a per-channel bit-history model predicts
// operands, fill validity, captured results and (with the macro) the signature.
module tb_shift_register_loader;
    localparam int N = 20;
    localparam int W = 20;
    localparam int D = 26;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
`ifdef SHIFT_REGISTER_LOADER_MISR_EN
    shift_register_loader_if #(.NUM_SRC(N), .SRC_WIDTH(W), .DST_WIDTH(D), .MISR_WIDTH(32)) bus ();
    shift_register_loader #(.NUM_SRC(N), .SRC_WIDTH(W), .DST_WIDTH(D), .MISR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`else
    shift_register_loader_if #(.NUM_SRC(N), .SRC_WIDTH(W), .DST_WIDTH(D)) bus ();
    shift_register_loader #(.NUM_SRC(N), .SRC_WIDTH(W), .DST_WIDTH(D)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif
    typedef struct packed {
        logic [N*W-1:0] src;
        logic           sv;
        logic           dv;
        logic [31:0]    misr;
    } exp_t;
    exp_t           cq[$];
    logic [D-1:0]   dq[$];
    int             checks = 0;
    int             errors = 0;
    bit             hist[N][$];
    int             m_shifts = 0;
    logic           m_valid = 1'b0;
    logic [31:0]    m_misr = '0;
    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic logic [N*W-1:0] model_src();
        logic [N*W-1:0] r = '0;
        for (int c = 0; c < N; c++)
            for (int k = 0; k < W; k++)
                if (k < hist[c].size()) r[c*W+k] = hist[c][hist[c].size()-1-k];
        return r;
    endfunction
    function automatic void model_zero();
        for (int c = 0; c < N; c++) hist[c].delete();
        m_shifts = 0;
        m_valid  = 1'b0;
        m_misr   = '0;
    endfunction
    task automatic step(input logic sh, input logic clr, input logic [N-1:0] b, input logic [D-1:0] d);
        exp_t e;
        logic dvn;
        @(negedge clk);
        bus.shift_en = sh;
        bus.clear    = clr;
        bus.src_     = b;
        bus.dst_in   = d;
        if (clr) begin
            model_zero();
            dvn = 1'b0;
        end else begin
            dvn = m_valid;
            if (dvn) dq.push_back(d);
`ifdef SHIFT_REGISTER_LOADER_MISR_EN
            if (m_valid) m_misr = (m_misr << 1) ^ (m_misr[31] ? 32'h00400007 : 32'h0) ^ 32'(d);
`endif
            if (sh) begin
                for (int c = 0; c < N; c++) begin
                    hist[c].push_back(b[c]);
                    if (hist[c].size() > W) void'(hist[c].pop_front());
                end
                m_shifts++;
            end
            m_valid = (m_shifts >= W);
        end
        e.src  = model_src();
        e.sv   = m_valid;
        e.dv   = dvn;
        e.misr = m_misr;
        cq.push_back(e);
    endtask
    task automatic rnd_step();
        step(($urandom % 10) < 7, ($urandom % 50) == 0, N'($urandom), D'($urandom));
    endtask
    task automatic settle();
        @(posedge clk);
        #2;
    endtask
    task automatic chk_zero(input string nm);
        chk({nm, "_src"}, 512'(bus.src), 512'(0));
        chk({nm, "_src_valid"}, 512'(bus.src_valid), 512'(0));
        chk({nm, "_dst_out"}, 512'(bus.dst_out), 512'(0));
        chk({nm, "_dst_valid"}, 512'(bus.dst_valid), 512'(0));
`ifdef SHIFT_REGISTER_LOADER_MISR_EN
        chk({nm, "_misr"}, 512'(bus.misr), 512'(0));
`endif
    endtask
    // monitor: per-cycle state checks plus result checks whenever dst_valid is presented
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (cq.size() > 0) begin
                e = cq.pop_front();
                chk("src", 512'(bus.src), 512'(e.src));
                chk("src_valid", 512'(bus.src_valid), 512'(e.sv));
                chk("dst_valid", 512'(bus.dst_valid), 512'(e.dv));
`ifdef SHIFT_REGISTER_LOADER_MISR_EN
                chk("misr", 512'(bus.misr), 512'(e.misr));
`endif
            end
            if (bus.dst_valid === 1'b1) begin
                if (dq.size() == 0) chk("dst_unexpected", 512'(1), 512'(0));
                else chk("dst_out", 512'(bus.dst_out), 512'(dq.pop_front()));
            end
        end
    end
    initial begin
        logic [N-1:0] b;
        rst = 1'b1;
        bus.clear = 1'b0;
        bus.shift_en = 1'b0;
        bus.src_ = '0;
        bus.dst_in = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (19) step(1'b1, 1'b0, '1, D'($urandom));
        settle();
        chk("fill19_valid", 512'(bus.src_valid), 512'(0));
        step(1'b1, 1'b0, '1, D'($urandom));
        settle();
        chk("fill20_valid", 512'(bus.src_valid), 512'(1));
        chk("fill20_src", 512'(bus.src), {112'b0, {400{1'b1}}});
        step(1'b0, 1'b1, '0, '0);
        for (int k = 0; k < W; k++) begin
            b = N'($urandom);
            b[0] = (k == 0);
            step(1'b1, 1'b0, b, D'($urandom));
        end
        settle();
        chk("order_ch0", 512'(bus.src[W-1:0]), 512'(20'h80000));
        b = N'($urandom);
        b[0] = 1'b0;
        step(1'b1, 1'b0, b, D'($urandom));
        settle();
        chk("order_drop_ch0", 512'(bus.src[W-1:0]), 512'(0));
        chk("order_drop_valid", 512'(bus.src_valid), 512'(1));
        repeat (5) step(1'b0, 1'b0, N'($urandom), D'($urandom));
        step(1'b1, 1'b1, '1, D'($urandom));
        settle();
        chk("clear_shift_src", 512'(bus.src), 512'(0));
        chk("clear_shift_valid", 512'(bus.src_valid), 512'(0));
        repeat (W) step(1'b1, 1'b0, N'($urandom), '0);
        step(1'b0, 1'b0, '0, 26'h2AAAAAA);
        settle();
        chk("capture_dst_out", 512'(bus.dst_out), 512'(26'h2AAAAAA));
        chk("capture_dst_valid", 512'(bus.dst_valid), 512'(1));
        step(1'b0, 1'b1, '0, D'($urandom));
        settle();
        chk("clear_dst_valid", 512'(bus.dst_valid), 512'(0));
        chk("clear_dst_out", 512'(bus.dst_out), 512'(0));
`ifdef SHIFT_REGISTER_LOADER_MISR_EN
        repeat (W) step(1'b1, 1'b0, N'($urandom), '0);
        step(1'b0, 1'b0, '0, D'(1));
        settle();
        chk("misr_first", 512'(bus.misr), 512'(32'h1));
        step(1'b0, 1'b0, '0, D'(1));
        settle();
        chk("misr_second", 512'(bus.misr), 512'(32'h3));
`endif
        repeat (400) rnd_step();
        // asynchronous reset in the middle of the low phase, with a shift pending
        @(negedge clk);
        bus.shift_en = 1'b1;
        bus.clear = 1'b0;
        bus.src_ = N'($urandom);
        bus.dst_in = D'($urandom);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        model_zero();
        cq.push_back('0);
        @(negedge clk);
        bus.shift_en = 1'b0;
        bus.dst_in = '0;
        rst = 1'b0;
        repeat (60) rnd_step();
        repeat (2) @(posedge clk);
        #2;
        chk("queues_drained", 512'(cq.size() + dq.size()), 512'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
